// File: rtl/timer_peripheral_pkg.sv
// Shared timer definitions: register offsets and TCON bit positions.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package timer_peripheral_pkg;

  // Byte offsets of the timer registers relative to the block base address.
  localparam logic [3:0] TIMER_TH      = 4'h0;
  localparam logic [3:0] TIMER_TL      = 4'h4;
  localparam logic [3:0] TIMER_TCON    = 4'h8;
  localparam logic [3:0] TIMER_SYSTICK = 4'hC;

  // TCON bit indices; the CPU exception logic uses these too.
  localparam int TCON_EN = 0;
  localparam int TCON_IE = 1;
  localparam int TCON_IS = 2;

  typedef enum logic [1:0] {
    SEL_TH      = 2'd0,
    SEL_TL      = 2'd1,
    SEL_TCON    = 2'd2,
    SEL_SYSTICK = 2'd3
  } timerSel_t;

endpackage

// File: rtl/timer_peripheral_prescaler.sv
// Mod-PRESCALE enable divider; tick marks the enabled cycle on which it wraps.
// Latency: tick is combinational from the current count and en.
// Backpressure: none; counts only while en=1, clr forces the count to 0.
// Ports: clk, reset (async active-low), en (count enable), clr (sync clear), tick (wrap strobe).
module timer_peripheral_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] count;

  // With PRESCALE==1 LAST is 0 and count never leaves 0, so tick == en.
  assign tick = en && (count == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= tick ? '0 : count + CW'(1);
    end
  end

endmodule

// File: rtl/timer_peripheral.sv
// Memory-mapped timer (TH reload, TL counter, TCON control/status, SYSTICK) with level interrupt.
// Latency: reads are combinational in the MemRead cycle; writes land on the next clk rising edge.
// Backpressure: none; every access completes in its own cycle.
// Ports: clk, reset (async active-low), memaddr/memwdata/MemRead/MemWrite (MEM-stage bus),
//        memrdata (read data, 0 when not hit), hit (address decode), intterupt (level, = TCON.IS).
module timer_peripheral
  import timer_peripheral_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int          PRESCALE  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] memaddr,
  input  logic [31:0] memwdata,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [31:0] memrdata,
  output logic        hit,
  output logic        intterupt
);

  logic [31:0] th;
  logic [31:0] tl;
  logic [31:0] systick;
  logic        en;
  logic        ie;
  logic        is;
  logic [31:0] tconVal;
  logic        tick;
  logic        overflow;
  logic        wrTh;
  logic        wrTl;
  logic        wrTcon;
  timerSel_t   sel;

  assign hit = (MemRead || MemWrite)
            && (memaddr[31:4] == BASE_ADDR[31:4])
            && (memaddr[1:0] == 2'b00);

  always_comb begin
    sel = SEL_TH;
    case (memaddr[3:0])
      TIMER_TH:      sel = SEL_TH;
      TIMER_TL:      sel = SEL_TL;
      TIMER_TCON:    sel = SEL_TCON;
      TIMER_SYSTICK: sel = SEL_SYSTICK;
      default:       sel = SEL_TH;
    endcase
  end

  assign wrTh   = MemWrite && hit && (sel == SEL_TH);
  assign wrTl   = MemWrite && hit && (sel == SEL_TL);
  assign wrTcon = MemWrite && hit && (sel == SEL_TCON);

  // The prescaler sees the pre-edge EN, so a TCON write that disables the
  // timer still lets a coinciding tick through.
  timer_peripheral_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .en   (en),
    .clr  (wrTcon && !memwdata[TCON_EN]),
    .tick (tick)
  );

  // A CPU write to TL suppresses both the increment and the overflow.
  assign overflow = tick && !wrTl && (tl == 32'hFFFF_FFFF);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      th      <= '0;
      tl      <= '0;
      systick <= '0;
      en      <= 1'b0;
      ie      <= 1'b0;
      is      <= 1'b0;
    end else begin
      systick <= systick + 32'd1;
      if (wrTh) th <= memwdata;
      // Reload takes th's pre-edge value even if th is written this cycle.
      if (wrTl) begin
        tl <= memwdata;
      end else if (tick) begin
        tl <= overflow ? th : tl + 32'd1;
      end
      if (wrTcon) begin
        en <= memwdata[TCON_EN];
        ie <= memwdata[TCON_IE];
      end
      // Set beats clear so an overflow racing a software clear is not lost;
      // software can only clear IS, never set it.
      if (overflow && ie) begin
        is <= 1'b1;
      end else if (wrTcon) begin
        is <= is & memwdata[TCON_IS];
      end
    end
  end

  assign intterupt = is;

  always_comb begin
    tconVal          = '0;
    tconVal[TCON_EN] = en;
    tconVal[TCON_IE] = ie;
    tconVal[TCON_IS] = is;
  end

  always_comb begin
    memrdata = '0;
    if (reset && MemRead && hit) begin
      case (sel)
        SEL_TH:      memrdata = th;
        SEL_TL:      memrdata = tl;
        SEL_TCON:    memrdata = tconVal;
        SEL_SYSTICK: memrdata = systick;
        default:     memrdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_timer_peripheral.sv
module tb_timer_peripheral;

  localparam logic [31:0] B = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] memaddr = '0;
  logic [31:0] memwdata = '0;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [31:0] rdata1, rdata4;
  logic        hit1, hit4, int1, int4;

  always #5 clk = ~clk;

  timer_peripheral #(.BASE_ADDR(B), .PRESCALE(1)) u_p1 (
    .clk(clk), .reset(reset), .memaddr(memaddr), .memwdata(memwdata),
    .MemRead(MemRead), .MemWrite(MemWrite),
    .memrdata(rdata1), .hit(hit1), .intterupt(int1)
  );

  timer_peripheral #(.BASE_ADDR(B), .PRESCALE(4)) u_p4 (
    .clk(clk), .reset(reset), .memaddr(memaddr), .memwdata(memwdata),
    .MemRead(MemRead), .MemWrite(MemWrite),
    .memrdata(rdata4), .hit(hit4), .intterupt(int4)
  );

  // Reference model: architectural register contents plus the number of
  // enabled cycles seen since the last prescaler clear (mod p).
  typedef struct {
    logic [31:0] th;
    logic [31:0] tl;
    logic [31:0] systick;
    bit          en;
    bit          ie;
    bit          is;
    int          enCnt;
  } mdl_t;

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] expR;
    bit          expH;
    bit          expI;
  } vec_t;

  mdl_t m1, m4;
  vec_t tbl[18];
  int   checks = 0;
  int   failures = 0;

  function automatic bit mHit(bit rd, bit wr, logic [31:0] a);
    return (rd || wr) && (a >= B) && (a < B + 32'd16) && (a % 4 == 0);
  endfunction

  function automatic logic [31:0] mRead(mdl_t m, bit rd, bit wr, logic [31:0] a);
    if (!(rd && mHit(rd, wr, a))) return 32'd0;
    case ((a - B) / 4)
      0:       return m.th;
      1:       return m.tl;
      2:       return {29'd0, m.is, m.ie, m.en};
      default: return m.systick;
    endcase
  endfunction

  function automatic mdl_t mStep(mdl_t m, int p, bit rd, bit wr, logic [31:0] a, logic [31:0] d);
    mdl_t n;
    bit   wHit, tk, ovf;
    int   idx;
    n    = m;
    wHit = wr && mHit(rd, wr, a);
    idx  = int'((a - B) >> 2);
    tk   = m.en && (((m.enCnt + 1) % p) == 0);
    n.systick = m.systick + 32'd1;
    if (m.en) n.enCnt = (m.enCnt + 1) % p;
    if (wHit && idx == 2 && !d[0]) n.enCnt = 0;
    ovf = tk && !(wHit && idx == 1) && (m.tl == 32'hFFFF_FFFF);
    if (wHit && idx == 0) n.th = d;
    if (wHit && idx == 1) n.tl = d;
    else if (tk) n.tl = ovf ? m.th : m.tl + 32'd1;
    if (wHit && idx == 2) begin
      n.en = d[0];
      n.ie = d[1];
      n.is = m.is & d[2];
    end
    if (ovf && m.ie) n.is = 1'b1;
    return n;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic checkModel();
    bit h;
    h = mHit(MemRead, MemWrite, memaddr);
    chk("p1_hit", 32'(hit1), 32'(h));
    chk("p4_hit", 32'(hit4), 32'(h));
    chk("p1_rdata", rdata1, reset ? mRead(m1, MemRead, MemWrite, memaddr) : 32'd0);
    chk("p4_rdata", rdata4, reset ? mRead(m4, MemRead, MemWrite, memaddr) : 32'd0);
    chk("p1_int", 32'(int1), 32'(m1.is));
    chk("p4_int", 32'(int4), 32'(m4.is));
  endtask

  task automatic drive(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
    MemRead  = rd;
    MemWrite = wr;
    memaddr  = a;
    memwdata = d;
    @(negedge clk);
    checkModel();
  endtask

  task automatic edgeStep();
    @(posedge clk);
    if (reset) begin
      m1 = mStep(m1, 1, MemRead, MemWrite, memaddr, memwdata);
      m4 = mStep(m4, 4, MemRead, MemWrite, memaddr, memwdata);
    end
    #1;
  endtask

  task automatic op(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
    drive(rd, wr, a, d);
    edgeStep();
  endtask

  // Asserts reset between clock edges and checks that outputs clear at once.
  task automatic doReset();
    MemRead  = 1'b1;
    MemWrite = 1'b0;
    memaddr  = B + 32'h4;
    #1;
    reset = 1'b0;
    #1;
    chk("rst_async_rdata_p1", rdata1, 32'd0);
    chk("rst_async_int_p1", 32'(int1), 32'd0);
    chk("rst_async_rdata_p4", rdata4, 32'd0);
    chk("rst_async_int_p4", 32'(int4), 32'd0);
    m1 = '{default: 0};
    m4 = '{default: 0};
    @(negedge clk);
    checkModel();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    // rd, wr, addr, wdata, expected rdata, expected hit, expected intterupt (PRESCALE=1)
    tbl[0]  = '{1'b0, 1'b1, B + 32'h0,  32'hFFFF_FFF0, 32'h0,         1'b1, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, B + 32'h4,  32'hFFFF_FFFE, 32'h0,         1'b1, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, B + 32'h8,  32'h3,         32'h0,         1'b1, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, B + 32'h4,  32'h0,         32'hFFFF_FFFE, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, B + 32'h4,  32'h0,         32'hFFFF_FFFF, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, B + 32'h4,  32'h0,         32'hFFFF_FFF0, 1'b1, 1'b1};
    tbl[6]  = '{1'b1, 1'b0, B + 32'h8,  32'h0,         32'h7,         1'b1, 1'b1};
    tbl[7]  = '{1'b0, 1'b1, B + 32'h8,  32'h3,         32'h0,         1'b1, 1'b1};
    tbl[8]  = '{1'b1, 1'b0, B + 32'h8,  32'h0,         32'h3,         1'b1, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, B + 32'h4,  32'h0,         32'hFFFF_FFF4, 1'b1, 1'b0};
    tbl[10] = '{1'b1, 1'b0, B + 32'h10, 32'h0,         32'h0,         1'b0, 1'b0};
    tbl[11] = '{1'b0, 1'b1, B + 32'h6,  32'hDEAD_BEEF, 32'h0,         1'b0, 1'b0};
    tbl[12] = '{1'b1, 1'b0, B + 32'h6,  32'h0,         32'h0,         1'b0, 1'b0};
    tbl[13] = '{1'b1, 1'b0, B + 32'hC,  32'h0,         32'd13,        1'b1, 1'b0};
    tbl[14] = '{1'b0, 1'b1, B + 32'hC,  32'h0,         32'h0,         1'b1, 1'b0};
    tbl[15] = '{1'b1, 1'b0, B + 32'hC,  32'h0,         32'd15,        1'b1, 1'b0};
    tbl[16] = '{1'b1, 1'b0, B + 32'h4,  32'h0,         32'hFFFF_FFFB, 1'b1, 1'b0};
    tbl[17] = '{1'b1, 1'b0, B + 32'h0,  32'h0,         32'hFFFF_FFF0, 1'b1, 1'b0};

    m1 = '{default: 0};
    m4 = '{default: 0};

    // Reads while held in reset return 0.
    for (int r = 0; r < 4; r++) begin
      drive(1'b1, 1'b0, B + 32'(4 * r), 32'h0);
      chk($sformatf("in_reset_rdata%0d", r), rdata1, 32'd0);
      edgeStep();
    end
    reset = 1'b1;

    // Directed table: overflow/reload, interrupt set/clear, decode, SYSTICK.
    for (int i = 0; i < 18; i++) begin
      drive(tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].d);
      chk($sformatf("tbl%0d_rdata", i), rdata1, tbl[i].expR);
      chk($sformatf("tbl%0d_hit", i), 32'(hit1), 32'(tbl[i].expH));
      chk($sformatf("tbl%0d_int", i), 32'(int1), 32'(tbl[i].expI));
      edgeStep();
    end

    // Software clear on the same edge as an overflow with IE=1: IS survives.
    op(1'b0, 1'b1, B + 32'h8, 32'h0);
    op(1'b0, 1'b1, B + 32'h0, 32'h100);
    op(1'b0, 1'b1, B + 32'h4, 32'hFFFF_FFFF);
    op(1'b0, 1'b1, B + 32'h8, 32'h3);
    op(1'b0, 1'b1, B + 32'h8, 32'h0);
    drive(1'b1, 1'b0, B + 32'h8, 32'h0);
    chk("set_beats_clear_tcon", rdata1, 32'h4);
    chk("set_beats_clear_int", 32'(int1), 32'd1);
    edgeStep();
    drive(1'b1, 1'b0, B + 32'h4, 32'h0);
    chk("set_beats_clear_reload", rdata1, 32'h100);
    edgeStep();

    // Mid-count reset with IS pending.
    op(1'b0, 1'b1, B + 32'h8, 32'h5);
    op(1'b1, 1'b0, B + 32'h4, 32'h0);
    drive(1'b1, 1'b0, B + 32'h8, 32'h0);
    chk("pre_reset_tcon", rdata1, 32'h5);
    edgeStep();
    doReset();
    drive(1'b1, 1'b0, B + 32'h0, 32'h0);
    chk("post_reset_th", rdata1, 32'h0);
    edgeStep();
    drive(1'b1, 1'b0, B + 32'h4, 32'h0);
    chk("post_reset_tl", rdata1, 32'h0);
    edgeStep();
    drive(1'b1, 1'b0, B + 32'h8, 32'h0);
    chk("post_reset_tcon", rdata1, 32'h0);
    edgeStep();
    drive(1'b1, 1'b0, B + 32'hC, 32'h0);
    chk("post_reset_systick", rdata1, 32'd3);
    edgeStep();

    // CPU write to TL on the overflow edge wins.
    op(1'b0, 1'b1, B + 32'h0, 32'h100);
    op(1'b0, 1'b1, B + 32'h4, 32'hFFFF_FFFF);
    op(1'b0, 1'b1, B + 32'h8, 32'h3);
    op(1'b0, 1'b1, B + 32'h4, 32'h5);
    drive(1'b1, 1'b0, B + 32'h4, 32'h0);
    chk("tl_write_wins", rdata1, 32'h5);
    chk("tl_write_wins_int", 32'(int1), 32'd0);
    edgeStep();

    // TH write on the overflow edge: reload uses old TH; IE=0 leaves IS clear.
    op(1'b0, 1'b1, B + 32'h8, 32'h0);
    op(1'b0, 1'b1, B + 32'h4, 32'hFFFF_FFFF);
    op(1'b0, 1'b1, B + 32'h8, 32'h1);
    op(1'b0, 1'b1, B + 32'h0, 32'h222);
    drive(1'b1, 1'b0, B + 32'h4, 32'h0);
    chk("old_th_reload", rdata1, 32'h100);
    chk("ie0_no_int", 32'(int1), 32'd0);
    edgeStep();
    drive(1'b1, 1'b0, B + 32'h0, 32'h0);
    chk("new_th", rdata1, 32'h222);
    edgeStep();

    // PRESCALE=4: 12 enabled cycles from TL=0 give TL=3.
    op(1'b0, 1'b1, B + 32'h8, 32'h0);
    op(1'b0, 1'b1, B + 32'h4, 32'h0);
    op(1'b0, 1'b1, B + 32'h8, 32'h1);
    for (int c = 0; c < 12; c++) op(1'b1, 1'b0, B + 32'h4, 32'h0);
    drive(1'b1, 1'b0, B + 32'h4, 32'h0);
    chk("prescale4_tl", rdata4, 32'd3);
    chk("prescale1_tl", rdata1, 32'd12);
    edgeStep();

    // Randomized bus traffic against the model.
    for (int i = 0; i < 600; i++) begin
      int          s;
      logic [31:0] a, d;
      bit          rd, wr;
      s = $urandom_range(0, 7);
      case (s)
        0, 1, 2, 3: a = B + 32'(4 * s);
        4:          a = B + 32'h10;
        5:          a = B + 32'($urandom_range(1, 3)) + 32'(4 * $urandom_range(0, 3));
        default:    a = $urandom;
      endcase
      d = $urandom;
      if (s == 1 && $urandom_range(0, 1) == 1) d = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      rd = 1'($urandom_range(0, 1));
      wr = ($urandom_range(0, 4) == 0);
      if (i == 300) doReset();
      op(rd, wr, a, d);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
